// File: rtl/fireball_unit.sv
// fireball_unit: one projectile slot answering the fireball controller's
// fire/ready handshake. Launches from the owner's position, flies one step per
// video frame, reports a single-cycle hit, then explodes and cools down before
// offering itself again.
module fireball_unit #(
  parameter int SPEED           = 4,
  parameter int FB_W            = 16,
  parameter int FB_H            = 16,
  parameter int OPP_W           = 32,
  parameter int OPP_H           = 64,
  parameter int LAUNCH_DX       = 24,
  parameter int LAUNCH_DY       = 20,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk_edge,
  input  logic       fire,
  input  logic [9:0] char_x,
  input  logic [9:0] char_y,
  input  logic       facing,
  input  logic [9:0] opp_x,
  input  logic [9:0] opp_y,
  input  logic       opp_alive,
  output logic       ready,
  output logic       active,
  output logic       exploding,
  output logic       hit,
  output logic [9:0] fb_x,
  output logic [9:0] fb_y
);

  localparam int MAXF  = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ? EXPLODE_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W = $clog2(MAXF) + 1;

  localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // All position math is 11 bits wide so sums past 1023 and left-launch
  // underflow are visible before clamping.
  localparam logic [10:0] R_LIM   = 11'(X_MAX - FB_W + 1);
  localparam logic [10:0] L_OFF   = 11'(LAUNCH_DX + FB_W);
  localparam logic [10:0] L_FLOOR = 11'(X_MIN + LAUNCH_DX + FB_W);
  localparam logic [10:0] XMIN11  = 11'(X_MIN);
  localparam logic [10:0] SPD11   = 11'(SPEED);
  localparam logic [10:0] DX11    = 11'(LAUNCH_DX);
  localparam logic [10:0] DY11    = 11'(LAUNCH_DY);
  localparam logic [10:0] FBW11   = 11'(FB_W);
  localparam logic [10:0] FBH11   = 11'(FB_H);
  localparam logic [10:0] OW11    = 11'(OPP_W);
  localparam logic [10:0] OH11    = 11'(OPP_H);

  typedef enum logic [1:0] {IDLE, FLY, EXPLODE, COOLDOWN} state_t;

  state_t           state_q, state_d;
  logic [9:0]       fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             ready_q, active_q, expl_q;

  logic [10:0] cx, cy, fx, fy, ox, oy;
  logic [10:0] launch_rx, launch_lx, right_sum;
  logic        overlap, offscreen;

  // Launch positions, overlap and off-screen tests on the current fireball box.
  always_comb begin
    cx        = {1'b0, char_x};
    cy        = {1'b0, char_y};
    fx        = {1'b0, fb_x_q};
    fy        = {1'b0, fb_y_q};
    ox        = {1'b0, opp_x};
    oy        = {1'b0, opp_y};
    right_sum = cx + DX11;
    launch_rx = (right_sum > R_LIM) ? R_LIM : right_sum;
    launch_lx = (cx < L_FLOOR) ? XMIN11 : (cx - L_OFF);
    overlap   = (fx < ox + OW11) && (ox < fx + FBW11) &&
                (fy < oy + OH11) && (oy < fy + FBH11);
    offscreen = dir_q ? (fx < XMIN11 + SPD11) : (fx + SPD11 > R_LIM);
  end

  // Next-state logic; everything except hit moves only on frame edges.
  always_comb begin
    state_d = state_q;
    fb_x_d  = fb_x_q;
    fb_y_d  = fb_y_q;
    dir_d   = dir_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    if (frame_clk_edge) begin
      // Releasing the key re-arms; a launch below overrides this.
      if (!fire) armed_d = 1'b1;
      case (state_q)
        IDLE: if (fire && armed_q) begin
          dir_d   = facing;
          fb_x_d  = facing ? 10'(launch_lx) : 10'(launch_rx);
          fb_y_d  = 10'(cy + DY11);
          armed_d = 1'b0;
          state_d = FLY;
        end
        FLY: begin
          // Hit beats off-screen when both happen on the same frame.
          if (overlap && opp_alive) begin
            hit_d   = 1'b1;
            cnt_d   = '0;
            state_d = EXPLODE;
          end else if (offscreen) begin
            cnt_d   = '0;
            state_d = COOLDOWN;
          end else begin
            fb_x_d  = dir_q ? 10'(fx - SPD11) : 10'(fx + SPD11);
          end
        end
        EXPLODE: begin
          if (cnt_q == EXP_LAST) begin
            cnt_d   = '0;
            state_d = COOLDOWN;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        COOLDOWN: begin
          if (cnt_q == CD_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + CNT_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with registered status outputs derived from next state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      fb_x_q   <= '0;
      fb_y_q   <= '0;
      dir_q    <= 1'b0;
      armed_q  <= 1'b1;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      expl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fb_x_q   <= fb_x_d;
      fb_y_q   <= fb_y_d;
      dir_q    <= dir_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      ready_q  <= (state_d == IDLE) && armed_d;
      active_q <= (state_d == FLY);
      expl_q   <= (state_d == EXPLODE);
    end
  end

  assign ready     = ready_q;
  assign active    = active_q;
  assign exploding = expl_q;
  assign hit       = hit_q;
  assign fb_x      = fb_x_q;
  assign fb_y      = fb_y_q;

endmodule

// File: tb/tb_fireball_unit.sv
// tb_fireball_unit: directed scenarios for one fireball slot with
// hand-computed positions and frame counts.
module tb_fireball_unit;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk_edge = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] char_x = '0, char_y = '0, opp_x = '0, opp_y = '0;
  logic       facing = 1'b0, opp_alive = 1'b0;
  logic       ready, active, exploding, hit;
  logic [9:0] fb_x, fb_y;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int h0;

  fireball_unit dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .fire(fire),
    .char_x(char_x), .char_y(char_y), .facing(facing),
    .opp_x(opp_x), .opp_y(opp_y), .opp_alive(opp_alive),
    .ready(ready), .active(active), .exploding(exploding), .hit(hit),
    .fb_x(fb_x), .fb_y(fb_y)
  );

  always #5 Clk = ~Clk;

  // Count every Clk cycle on which hit is high; a one-cycle pulse adds one.
  always @(negedge Clk) if (hit === 1'b1) hit_cnt++;

  // One frame: frame_clk_edge high for exactly one Clk, then one quiet Clk.
  task automatic frame();
    @(negedge Clk) frame_clk_edge = 1'b1;
    @(negedge Clk) frame_clk_edge = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    opp_alive = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (active !== 1'b0 || exploding !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL reset_flags: got a=%b e=%b h=%b expected 0", active, exploding, hit); end
    checks++; if (fb_x !== 10'd0 || fb_y !== 10'd0) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", fb_x, fb_y); end
    // Launch to x=300, then reset mid-flight.
    facing = 1'b0; char_x = 10'd276; char_y = 10'd100; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd300 || active !== 1'b1) begin errors++; $display("FAIL reset_prelaunch: got x=%0d a=%b expected 300,1", fb_x, active); end
    @(negedge Clk) Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    checks++; if (ready !== 1'b1 || active !== 1'b0 || fb_x !== 10'd0 || hit_cnt != 0) begin
      errors++; $display("FAIL reset_midflight: got r=%b a=%b x=%0d hits=%0d expected 1,0,0,0", ready, active, fb_x, hit_cnt); end
  endtask

  task automatic test_fly_right();
    h0 = hit_cnt;
    opp_x = 10'd600; opp_y = 10'd0; opp_alive = 1'b1;
    facing = 1'b0; char_x = 10'd100; char_y = 10'd200; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd124 || fb_y !== 10'd220) begin errors++; $display("FAIL right_launch: got %0d,%0d expected 124,220", fb_x, fb_y); end
    checks++; if (active !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL right_launch_flags: got a=%b r=%b expected 1,0", active, ready); end
    repeat (10) frame();
    checks++; if (fb_x !== 10'd164) begin errors++; $display("FAIL right_10frames: got %0d expected 164", fb_x); end
    repeat (115) frame();
    checks++; if (fb_x !== 10'd624 || active !== 1'b1) begin errors++; $display("FAIL right_edge: got x=%0d a=%b expected 624,1", fb_x, active); end
    frame();
    checks++; if (active !== 1'b0 || exploding !== 1'b0 || fb_x !== 10'd624 || ready !== 1'b0) begin
      errors++; $display("FAIL right_exit: got a=%b e=%b x=%0d r=%b expected 0,0,624,0", active, exploding, fb_x, ready); end
    repeat (14) frame();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL right_cooldown14: got %b expected 0", ready); end
    frame();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL right_cooldown15: got %b expected 1", ready); end
    checks++; if (hit_cnt != h0) begin errors++; $display("FAIL right_nohit: got %0d expected %0d", hit_cnt, h0); end
  endtask

  task automatic test_hit_left();
    h0 = hit_cnt;
    opp_x = 10'd200; opp_y = 10'd200; opp_alive = 1'b1;
    facing = 1'b1; char_x = 10'd300; char_y = 10'd200; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd260 || fb_y !== 10'd220) begin errors++; $display("FAIL left_launch: got %0d,%0d expected 260,220", fb_x, fb_y); end
    repeat (8) frame();
    checks++; if (fb_x !== 10'd228 || active !== 1'b1 || hit_cnt != h0) begin
      errors++; $display("FAIL left_approach: got x=%0d a=%b hits=%0d expected 228,1,%0d", fb_x, active, hit_cnt, h0); end
    // Hit edge: sample right after the frame edge, then one Clk later.
    @(negedge Clk) frame_clk_edge = 1'b1;
    @(negedge Clk) frame_clk_edge = 1'b0;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b expected 1", hit); end
    @(negedge Clk);
    checks++; if (hit !== 1'b0 || hit_cnt != h0 + 1) begin errors++; $display("FAIL hit_single: got h=%b hits=%0d expected 0,%0d", hit, hit_cnt, h0 + 1); end
    checks++; if (exploding !== 1'b1 || active !== 1'b0 || fb_x !== 10'd228) begin
      errors++; $display("FAIL hit_explode: got e=%b a=%b x=%0d expected 1,0,228", exploding, active, fb_x); end
    repeat (7) frame();
    checks++; if (exploding !== 1'b1) begin errors++; $display("FAIL explode_7: got %b expected 1", exploding); end
    frame();
    checks++; if (exploding !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL explode_8: got e=%b r=%b expected 0,0", exploding, ready); end
    repeat (14) frame();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hit_cooldown14: got %b expected 0", ready); end
    frame();
    checks++; if (ready !== 1'b1 || hit_cnt != h0 + 1) begin errors++; $display("FAIL hit_cooldown15: got r=%b hits=%0d expected 1,%0d", ready, hit_cnt, h0 + 1); end
  endtask

  task automatic test_fire_held();
    opp_alive = 1'b0;
    facing = 1'b0; char_x = 10'd500; char_y = 10'd100; fire = 1'b1;
    frame();
    checks++; if (fb_x !== 10'd524 || active !== 1'b1) begin errors++; $display("FAIL held_launch: got x=%0d a=%b expected 524,1", fb_x, active); end
    repeat (59) frame();
    checks++; if (ready !== 1'b0 || active !== 1'b0 || fb_x !== 10'd624) begin
      errors++; $display("FAIL held_norelaunch: got r=%b a=%b x=%0d expected 0,0,624", ready, active, fb_x); end
    fire = 1'b0;
    frame();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL held_rearm: got %b expected 1", ready); end
  endtask

  task automatic test_pass_through();
    h0 = hit_cnt;
    opp_x = 10'd110; opp_y = 10'd200; opp_alive = 1'b0;
    facing = 1'b0; char_x = 10'd100; char_y = 10'd200; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd124 || active !== 1'b1) begin errors++; $display("FAIL pass_launch: got x=%0d a=%b expected 124,1", fb_x, active); end
    repeat (125) frame();
    checks++; if (fb_x !== 10'd624 || active !== 1'b1) begin errors++; $display("FAIL pass_edge: got x=%0d a=%b expected 624,1", fb_x, active); end
    frame();
    checks++; if (active !== 1'b0 || exploding !== 1'b0 || hit_cnt != h0) begin
      errors++; $display("FAIL pass_exit: got a=%b e=%b hits=%0d expected 0,0,%0d", active, exploding, hit_cnt, h0); end
    repeat (15) frame();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pass_ready: got %b expected 1", ready); end
  endtask

  task automatic test_clamp();
    opp_alive = 1'b0;
    facing = 1'b1; char_x = 10'd10; char_y = 10'd50; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd0 || active !== 1'b1) begin errors++; $display("FAIL clamp_left: got x=%0d a=%b expected 0,1", fb_x, active); end
    frame();
    checks++; if (fb_x !== 10'd0 || active !== 1'b0 || exploding !== 1'b0) begin
      errors++; $display("FAIL clamp_left_exit: got x=%0d a=%b e=%b expected 0,0,0", fb_x, active, exploding); end
    repeat (15) frame();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clamp_left_ready: got %b expected 1", ready); end
    facing = 1'b0; char_x = 10'd620; fire = 1'b1;
    frame();
    fire = 1'b0;
    checks++; if (fb_x !== 10'd624 || active !== 1'b1) begin errors++; $display("FAIL clamp_right: got x=%0d a=%b expected 624,1", fb_x, active); end
    frame();
    checks++; if (active !== 1'b0 || fb_x !== 10'd624) begin errors++; $display("FAIL clamp_right_exit: got a=%b x=%0d expected 0,624", active, fb_x); end
  endtask

  initial begin
    test_reset();
    test_fly_right();
    test_hit_left();
    test_fire_held();
    test_pass_through();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fireball_unit.md
Name: fireball_unit

Overview:
- One projectile slot, and the responder side of the fire/ready handshake driven by the fireball controller.
- Advertises `ready` while parked. It accepts a `fire` strobe and launches from the owning character's position, then advances once per frame.
- It detects collision with the opponent's hitbox and reports a hit pulse to the health logic. It then plays an explosion and cooldown before re-advertising `ready`.
- Five instances sit beside the controller, one per fire/ready pair; the sprite renderer consumes `fb_x`, `fb_y`, `active` and `exploding`.

Parameters:
- SPEED, 4, pixels moved per frame_clk_edge
- FB_W, 16, fireball width in pixels
- FB_H, 16, fireball height in pixels
- OPP_W, 32, opponent hitbox width
- OPP_H, 64, opponent hitbox height
- LAUNCH_DX, 24, horizontal launch offset from char_x
- LAUNCH_DY, 20, vertical launch offset from char_y
- X_MIN, 0, left playfield edge
- X_MAX, 639, right playfield edge
- EXPLODE_FRAMES, 8, frames spent in EXPLODE
- COOLDOWN_FRAMES, 15, frames spent in COOLDOWN

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- frame_clk_edge  in  1  one-Clk pulse per video frame
- fire  in  1  launch request from the controller (level, may stay high for many frames)
- char_x  in  10  owning character's left x
- char_y  in  10  owning character's top y
- facing  in  1  0 = right, 1 = left
- opp_x  in  10  opponent hitbox left x
- opp_y  in  10  opponent hitbox top y
- opp_alive  in  1  opponent can be hit
- ready  out  1  slot idle and armed
- active  out  1  fireball in flight
- exploding  out  1  explosion sprite enable
- hit  out  1  one-Clk pulse on collision
- fb_x  out  10  fireball left x
- fb_y  out  10  fireball top y

Behaviour:
- Reset is synchronous and active-low: Reset == 0 sampled at posedge Clk resets the block. Reset values:
  - state = IDLE, ready = 1, active = 0, exploding = 0, hit = 0
  - fb_x = 0, fb_y = 0, dir = 0, frame counter = 0, armed = 1
- Reset mid-flight returns to IDLE in the same edge; no hit pulse is produced.
- All state changes occur only on Clk edges where frame_clk_edge = 1, except that `hit` clears on the next Clk.
- Outputs are registered. `ready` = (state == IDLE && armed); `active` = (state == FLY); `exploding` = (state == EXPLODE).
- Re-arm rule:
  - The controller holds `fire` while the key is held, so a launch clears `armed`.
  - `armed` sets on any frame edge where fire = 0.
  - A launch requires armed = 1, so one key hold yields exactly one fireball from this slot.
- IDLE:
  - On a frame edge with fire = 1 and armed = 1: latch dir = facing, set fb_y = char_y + LAUNCH_DY, clear armed, go to FLY.
  - fb_x = char_x + LAUNCH_DX if dir = 0.
  - fb_x = max(X_MIN, char_x − LAUNCH_DX − FB_W) if dir = 1.
  - Launch arithmetic is done in 11 bits: a right launch whose sum exceeds X_MAX − FB_W + 1 is clamped to X_MAX − FB_W + 1; a left launch that underflows is clamped to X_MIN.
- FLY, each frame edge, in this priority order:
  1. Hit: boxes overlap on the current fb_x/fb_y and opp_alive = 1.
     - Overlap means fb_x < opp_x + OPP_W, opp_x < fb_x + FB_W, fb_y < opp_y + OPP_H and opp_y < fb_y + FB_H (11-bit compares).
     - On a hit: pulse hit for 1 Clk, hold position, counter = 0, go to EXPLODE.
  2. Off-screen: dir = 0 and fb_x + SPEED > X_MAX − FB_W + 1, or dir = 1 and fb_x < X_MIN + SPEED.
     - Go to COOLDOWN with counter = 0 and no explosion; fb_x holds its last value.
  3. Otherwise fb_x ± SPEED.
  - Hit and off-screen on the same frame: hit wins.
- EXPLODE: counter increments per frame; when counter = EXPLODE_FRAMES − 1, go to COOLDOWN with counter = 0.
- COOLDOWN: when counter = COOLDOWN_FRAMES − 1, go to IDLE. `ready` rises only if armed = 1.
- `fire` outside IDLE is ignored, apart from updating `armed`. `hit` never asserts outside FLY.
- Counter width is ceil(log2(max(EXPLODE_FRAMES, COOLDOWN_FRAMES))) + 1.

Test Plan:
- Reset = 0 for 3 Clk mid-flight (fb_x = 300) -> next Clk: ready = 1, active = 0, fb_x = 0, hit = 0.
- char_x = 100, char_y = 200, facing = 0, opponent at x = 600, fire = 1 for 1 frame then 0 -> launch fb_x = 124, fb_y = 220; after 10 frames fb_x = 164; leaves at fb_x = 624 with a 15-frame cooldown; ready = 1 on the following edge; hit never asserted.
- facing = 1, char_x = 300, opponent at x = 200, y = 200, opp_alive = 1 -> fb_x starts at 260, moves −4 per frame; the first frame with fb_x < 232 asserts a single-Clk hit; exploding = 1 for 8 frames, then cooldown for 15 frames.
- fire held high 60 frames across a full flight and cooldown -> exactly one launch; ready stays 0 after cooldown until fire = 0 on a frame edge, then ready = 1.
- opp_alive = 0 with the opponent overlapping the launch point -> no hit; the fireball passes through and exits normally.
- facing = 1, char_x = 10 -> launch clamped to fb_x = 0; next frame is the off-screen branch to COOLDOWN; no underflow wrap to 1023.
